iob_plic_gw_arb: RTL and testbench
==================================

Name: iob_plic_gw_arb

Overview:
Parametrised next-generation PLIC core with an IOb native slave register interface. Each source gets a runtime-selectable level/edge gateway with a saturating pending counter. Each target gets a registered priority arbiter with threshold and a claim/complete handshake. It sits between peripheral interrupt lines and the CPU external-interrupt inputs (meip), and replaces the fixed-mode PLIC core in the SoC and simulation wrappers.

Parameters:
ADDR_W, 16, IOb address width (byte address)
DATA_W, 32, IOb data width; fixed at 32
N_SOURCES, 8, number of sources, IDs 1..N_SOURCES, range 1..31; ID 0 is reserved (no interrupt)
N_TARGETS, 2, number of targets, range 1..8
PRIORITIES, 8, priority levels; PRIO_W = clog2(PRIORITIES); 0 = never interrupts
MAX_PENDING_COUNT, 8, edge-mode pending counter saturation value, >=1
HAS_THRESHOLD, 1, 1 = per-target threshold register; 0 = threshold reads 0 and writes are ignored

Ports:
clk_i  in  1  clock
arst_n_i  in  1  asynchronous active-low reset
cke_i  in  1  clock enable; all state holds when 0
iob_avalid  in  1  request valid
iob_addr  in  ADDR_W  byte address
iob_wdata  in  DATA_W  write data
iob_wstrb  in  DATA_W/8  byte strobes; all zero = read
iob_ready  out  1  request accepted; constant 1
iob_rvalid  out  1  read data valid
iob_rdata  out  DATA_W  read data
src  in  N_SOURCES  interrupt lines; bit i-1 = source i
irq  out  N_TARGETS  per-target interrupt request

Behaviour:
- Reset: every register is cleared. irq=0, iob_rvalid=0, iob_rdata=0, all priorities, enables, thresholds, modes and counters are 0, in-service=0, and src sample register=0. After reset all sources are in level mode.
- Register map (word aligned, byte offsets):
  - 0x000+4*s: priority[s], RW, s=1..N; s=0 or s>N read 0.
  - 0x080: pending bitmap, RO, bit s.
  - 0x084: mode bitmap, RW, bit s, 1=edge.
  - 0x100+0x10*t: enable bitmap for target t.
  - 0x104+0x10*t: threshold.
  - 0x108+0x10*t: claim on read, complete on write.
  - Unmapped addresses read 0; writes to them are ignored.
- Bus:
  - Write = avalid & |wstrb; only strobed bytes are updated.
  - Read = avalid & ~|wstrb. iob_rvalid is high exactly one cycle after the read, with rdata; otherwise rvalid=0 and rdata holds.
  - Back-to-back requests are allowed every cycle.
- Gateway (per source, registered):
  - Level mode: pending = src & ~in_service.
  - Edge mode: a rising edge (src & ~src_q) increments the counter, which saturates at MAX_PENDING_COUNT. pending = (cnt!=0) & ~in_service.
  - Claim: sets in_service. Edge mode also decrements cnt. Edge + claim in the same cycle leaves cnt unchanged.
  - Writing the mode bit of a source clears its counter and src_q for that source.
- Arbiter (per target t):
  - Candidate = pending & enable[t] & priority > threshold[t].
  - Winner = highest priority; ties go to the lowest ID. No candidate gives ID 0.
  - irq[t] and id_q[t] are registered, so they reflect state one cycle after it changes.
- Latency: src rises at edge n → pending visible at n+1 → irq at n+2.
- Claim (read of 0x108+0x10*t):
  - Returns id_q[t] as sampled in the accept cycle.
  - If the ID is non-zero, that source's in_service is set in the same cycle. The source's pending drops, and irq updates at the next edge.
  - A claim returning 0 has no side effects.
- Complete (write of 0x108+0x10*t): wdata[4:0]=ID in 1..N clears in_service[ID]. ID 0 or ID>N is ignored. Completing a source that is not in service is a no-op.
- A source claimed by one target is blocked for all targets until it is completed.
- cke_i=0 freezes all state, including rvalid.
- Asynchronous reset mid-operation returns immediately to reset values. A read accepted in the reset cycle never produces rvalid.

Decomposition:
- Shared include iob_plic_gw_arb_conf.vh: register offsets, PRIO_W, CNT_W = clog2(MAX_PENDING_COUNT+1), ID_W = 5.
- One sub-module, iob_plic_gateway: per-source src_q, counter, in_service and pending, with claim/complete/mode-write inputs. It is instantiated N_SOURCES times by generate.
- The arbiter and register file stay in the top.

Test Plan:
- Level source 3, prio 5, enabled on target 0, threshold 0. Raise src[2] → irq[0]=1 two cycles later. Claim read returns 3 and irq[0] drops next cycle. Complete with 3 while src still high → irq[0] re-asserts after 2 cycles.
- Edge source 1, prio 2, 10 pulses, MAX_PENDING_COUNT=8. Claim/complete repeated: exactly 8 claims return 1, the 9th claim returns 0.
- Sources 2 and 4 both prio 3, source 6 prio 1, all pending on target 1 → claims return 2, then 4, then 6.
- Threshold 3 on target 0, source 5 prio 3 pending → irq[0]=0. Set prio 4 → irq[0]=1 two cycles after the write.
- Source 7 enabled on targets 0 and 1. Target 0 claims 7 → irq[1] drops and a target-1 claim returns 0. Complete via target 1 with 7 → both irq lines re-assert.
- Assert arst_n_i low during a read-accept cycle → rvalid stays 0, irq=0, and all registers read 0 after release.

Source files
------------

// File: rtl/iob_plic_gw_arb_pkg.sv
// iob_plic_gw_arb_pkg: shared register map, field widths and byte-strobe merge helper
package iob_plic_gw_arb_pkg;
    localparam int ID_W = 5;
    localparam logic [11:0] PEND_ADDR = 12'h080;
    localparam logic [11:0] MODE_ADDR = 12'h084;
    localparam logic [11:0] TGT_BASE  = 12'h100;
    typedef enum logic [1:0] {
        TREG_ENABLE = 2'd0,
        TREG_THRESH = 2'd1,
        TREG_CLAIM  = 2'd2,
        TREG_RSVD   = 2'd3
    } treg_e;
    function automatic logic [31:0] wmerge(input logic [31:0] old_v, input logic [31:0] new_v, input logic [3:0] strb);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
        return r;
    endfunction
endpackage

// File: rtl/iob_plic_gw_arb_gateway.sv
// iob_plic_gateway: per-source sampler, saturating edge counter and in-service flag producing pending
module iob_plic_gateway #(
    parameter int MAX_PENDING_COUNT = 8,
    parameter int CNT_W = $clog2(MAX_PENDING_COUNT + 1)
) (
    input  logic clk_i,
    input  logic arst_n_i,
    input  logic cke_i,
    input  logic src_i,
    input  logic edge_i,
    input  logic claim_i,
    input  logic complete_i,
    input  logic mode_wr_i,
    output logic pending_o
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PENDING_COUNT);
    logic src_q, src_d, ins_q, ins_d, rise;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // Next state: a coincident edge and claim cancel, mode writes restart edge detection
    always_comb begin
        rise = src_i & ~src_q;
        src_d = mode_wr_i ? 1'b0 : src_i;
        ins_d = claim_i ? 1'b1 : complete_i ? 1'b0 : ins_q;
        cnt_d = mode_wr_i ? '0
              : (!edge_i || (rise && claim_i)) ? cnt_q
              : rise ? (cnt_q == CNT_MAX ? cnt_q : cnt_q + CNT_W'(1))
              : (claim_i && cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
        pending_o = (edge_i ? cnt_q != '0 : src_q) & ~ins_q;
    end
    // Gateway state registers, frozen while the clock enable is low
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            src_q <= 1'b0;
            ins_q <= 1'b0;
            cnt_q <= '0;
        end else if (cke_i) begin
            src_q <= src_d;
            ins_q <= ins_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/iob_plic_gw_arb.sv
// iob_plic_gw_arb: PLIC core with level/edge gateways, per-target priority arbiters and an IOb register slave
module iob_plic_gw_arb
    import iob_plic_gw_arb_pkg::*;
#(
    parameter int ADDR_W            = 16,
    parameter int DATA_W            = 32,
    parameter int N_SOURCES         = 8,
    parameter int N_TARGETS         = 2,
    parameter int PRIORITIES        = 8,
    parameter int MAX_PENDING_COUNT = 8,
    parameter int HAS_THRESHOLD     = 1
) (
    input  logic                 clk_i,
    input  logic                 arst_n_i,
    input  logic                 cke_i,
    input  logic                 iob_avalid,
    input  logic [ADDR_W-1:0]    iob_addr,
    input  logic [DATA_W-1:0]    iob_wdata,
    input  logic [DATA_W/8-1:0]  iob_wstrb,
    output logic                 iob_ready,
    output logic                 iob_rvalid,
    output logic [DATA_W-1:0]    iob_rdata,
    input  logic [N_SOURCES-1:0] src,
    output logic [N_TARGETS-1:0] irq
);
    localparam int PRIO_W = PRIORITIES > 1 ? $clog2(PRIORITIES) : 1;
    localparam int CNT_W = $clog2(MAX_PENDING_COUNT + 1);
    localparam logic [31:0] SRC_MASK = ((32'd1 << N_SOURCES) - 32'd1) << 1;

    logic [PRIO_W-1:0] prio_q [1:N_SOURCES];
    logic [PRIO_W-1:0] prio_d [1:N_SOURCES];
    logic [31:0] mode_q, mode_d;
    logic [31:0] en_q [N_TARGETS];
    logic [31:0] en_d [N_TARGETS];
    logic [PRIO_W-1:0] thr_q [N_TARGETS];
    logic [PRIO_W-1:0] thr_d [N_TARGETS];
    logic [PRIO_W-1:0] best_p [N_TARGETS];
    logic [ID_W-1:0] id_q [N_TARGETS];
    logic [ID_W-1:0] id_d [N_TARGETS];
    logic [N_TARGETS-1:0] irq_q, irq_d;
    logic rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d, pend_w;
    logic [N_SOURCES:1] claim_s, complete_s, mode_wr_s, pend_s;
    logic wr, rd, is_prio, is_pend, is_mode, is_tgt, unused_addr;
    logic [4:0] psel;
    logic [2:0] tsel;
    treg_e treg;

    assign iob_ready = 1'b1;
    assign iob_rvalid = rvalid_q;
    assign iob_rdata = rdata_q;
    assign irq = irq_q;
    assign wr = iob_avalid & |iob_wstrb;
    assign rd = iob_avalid & ~|iob_wstrb;
    assign is_prio = iob_addr[ADDR_W-1:7] == '0;
    assign is_pend = iob_addr[ADDR_W-1:2] == (ADDR_W-2)'(PEND_ADDR[11:2]);
    assign is_mode = iob_addr[ADDR_W-1:2] == (ADDR_W-2)'(MODE_ADDR[11:2]);
    assign is_tgt = iob_addr[ADDR_W-1:7] == (ADDR_W-7)'(TGT_BASE[11:7]);
    assign psel = iob_addr[6:2];
    assign tsel = iob_addr[6:4];
    assign treg = treg_e'(iob_addr[3:2]);
    assign unused_addr = ^iob_addr[1:0];

    for (genvar g = 1; g <= N_SOURCES; g++) begin : g_gw
        iob_plic_gateway #(
            .MAX_PENDING_COUNT(MAX_PENDING_COUNT),
            .CNT_W(CNT_W)
        ) u_gw (
            .clk_i(clk_i),
            .arst_n_i(arst_n_i),
            .cke_i(cke_i),
            .src_i(src[g-1]),
            .edge_i(mode_q[g]),
            .claim_i(claim_s[g]),
            .complete_i(complete_s[g]),
            .mode_wr_i(mode_wr_s[g]),
            .pending_o(pend_s[g])
        );
    end

    // Register writes, read mux and per-source claim/complete/mode-write strobes
    always_comb begin
        prio_d = prio_q;
        mode_d = mode_q;
        en_d = en_q;
        thr_d = thr_q;
        rvalid_d = rd;
        rdata_d = rd ? '0 : rdata_q;
        claim_s = '0;
        complete_s = '0;
        mode_wr_s = '0;
        pend_w = '0;
        for (int s = 1; s <= N_SOURCES; s++) pend_w[s] = pend_s[s];
        if (wr && is_mode) mode_d = wmerge(mode_q, iob_wdata, iob_wstrb) & SRC_MASK;
        if (rd && is_pend) rdata_d = pend_w;
        if (rd && is_mode) rdata_d = mode_q;
        for (int s = 1; s <= N_SOURCES; s++) begin
            if (is_prio && psel == 5'(s)) begin
                if (wr && iob_wstrb[0]) prio_d[s] = iob_wdata[PRIO_W-1:0];
                if (rd) rdata_d = 32'(prio_q[s]);
            end
            mode_wr_s[s] = wr && is_mode && iob_wstrb[s/8];
        end
        for (int t = 0; t < N_TARGETS; t++) begin
            if (is_tgt && tsel == 3'(t)) begin
                if (wr && treg == TREG_ENABLE) en_d[t] = wmerge(en_q[t], iob_wdata, iob_wstrb) & SRC_MASK;
                if (wr && treg == TREG_THRESH && iob_wstrb[0] && HAS_THRESHOLD != 0) thr_d[t] = iob_wdata[PRIO_W-1:0];
                if (rd) rdata_d = treg == TREG_ENABLE ? en_q[t]
                                : treg == TREG_THRESH ? 32'(thr_q[t])
                                : treg == TREG_CLAIM ? 32'(id_q[t]) : '0;
                for (int s = 1; s <= N_SOURCES; s++) begin
                    claim_s[s] = claim_s[s] | (rd && treg == TREG_CLAIM && id_q[t] == ID_W'(s));
                    complete_s[s] = complete_s[s] | (wr && treg == TREG_CLAIM && iob_wstrb[0] && iob_wdata[ID_W-1:0] == ID_W'(s));
                end
            end
        end
    end

    // Per-target winner: highest priority strictly above threshold, lowest ID wins ties
    always_comb begin
        for (int t = 0; t < N_TARGETS; t++) begin
            best_p[t] = thr_q[t];
            id_d[t] = '0;
            for (int s = 1; s <= N_SOURCES; s++) begin
                if (pend_s[s] && en_q[t][s] && prio_q[s] > best_p[t]) begin
                    best_p[t] = prio_q[s];
                    id_d[t] = ID_W'(s);
                end
            end
            irq_d[t] = id_d[t] != '0;
        end
    end

    // Register file, read response and registered arbiter outputs; all hold while cke_i is low
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            for (int s = 1; s <= N_SOURCES; s++) prio_q[s] <= '0;
            for (int t = 0; t < N_TARGETS; t++) begin
                en_q[t] <= '0;
                thr_q[t] <= '0;
                id_q[t] <= '0;
            end
            mode_q <= '0;
            irq_q <= '0;
            rvalid_q <= 1'b0;
            rdata_q <= '0;
        end else if (cke_i) begin
            prio_q <= prio_d;
            en_q <= en_d;
            thr_q <= thr_d;
            id_q <= id_d;
            mode_q <= mode_d;
            irq_q <= irq_d;
            rvalid_q <= rvalid_d;
            rdata_q <= rdata_d;
        end
    end
endmodule

// File: tb/tb_iob_plic_gw_arb.sv
// tb_iob_plic_gw_arb: directed plan scenarios plus randomized traffic against a rule-level PLIC model
module tb_iob_plic_gw_arb;
    localparam int N = 8;
    localparam int T = 2;
    localparam int MAXC = 8;
    localparam int PMAX = 7;

    logic clk_i = 1'b0, arst_n_i = 1'b0, cke_i = 1'b1, iob_avalid = 1'b0;
    logic [15:0] iob_addr = '0;
    logic [31:0] iob_wdata = '0;
    logic [3:0] iob_wstrb = '0;
    logic iob_ready, iob_rvalid;
    logic [31:0] iob_rdata;
    logic [N-1:0] src = '0;
    logic [T-1:0] irq;

    int checks = 0, errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_e;

    int m_prio[N+1];
    int m_cnt[N+1];
    bit m_ins[N+1];
    bit m_src[N+1];
    logic [31:0] m_mode;
    logic [31:0] m_en[T];
    int m_thr[T];
    logic [15:0] rd_addrs[15] = '{16'h000, 16'h004, 16'h00C, 16'h014, 16'h01C, 16'h020, 16'h024,
                                  16'h080, 16'h084, 16'h100, 16'h104, 16'h110, 16'h114, 16'h120, 16'h200};

    iob_plic_gw_arb dut (
        .clk_i(clk_i), .arst_n_i(arst_n_i), .cke_i(cke_i),
        .iob_avalid(iob_avalid), .iob_addr(iob_addr), .iob_wdata(iob_wdata), .iob_wstrb(iob_wstrb),
        .iob_ready(iob_ready), .iob_rvalid(iob_rvalid), .iob_rdata(iob_rdata),
        .src(src), .irq(irq)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    always @(negedge clk_i) begin
        if (iob_rvalid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rvalid_unexpected: got rdata %0h, required no rvalid", iob_rdata);
            end else begin
                mon_e = exp_q.pop_front();
                check("rdata", iob_rdata, mon_e);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1);
    end

    function automatic bit pend(input int s);
        return (m_mode[s] ? m_cnt[s] != 0 : m_src[s]) && !m_ins[s];
    endfunction

    function automatic int winner(input int t);
        for (int p = PMAX; p > m_thr[t]; p--)
            for (int s = 1; s <= N; s++)
                if (m_prio[s] == p && m_en[t][s] && pend(s)) return s;
        return 0;
    endfunction

    function automatic logic [31:0] exp_irq();
        logic [31:0] v = '0;
        for (int t = 0; t < T; t++) v[t] = winner(t) != 0;
        return v;
    endfunction

    function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] st);
        logic [31:0] r = o;
        for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = d[8*b +: 8];
        return r & 32'h1FE;
    endfunction

    function automatic void model_reset();
        for (int s = 0; s <= N; s++) begin
            m_prio[s] = 0; m_cnt[s] = 0; m_ins[s] = 0; m_src[s] = 0;
        end
        m_mode = '0;
        for (int t = 0; t < T; t++) begin
            m_en[t] = '0; m_thr[t] = 0;
        end
    endfunction

    function automatic void model_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] st);
        int s = int'(a[6:2]);
        int t = int'(a[6:4]);
        logic [31:0] nm;
        if (a[15:7] == 0) begin
            if (s >= 1 && s <= N && st[0]) m_prio[s] = int'(d[2:0]);
        end else if (a == 16'h084) begin
            nm = bmerge(m_mode, d, st);
            for (int k = 1; k <= N; k++) if (st[k/8]) m_cnt[k] = (nm[k] && m_src[k]) ? 1 : 0;
            m_mode = nm;
        end else if (a[15:7] == 2 && t < T) begin
            if (a[3:2] == 0) m_en[t] = bmerge(m_en[t], d, st);
            if (a[3:2] == 1 && st[0]) m_thr[t] = int'(d[2:0]);
            if (a[3:2] == 2 && st[0] && d[4:0] >= 1 && d[4:0] <= N) m_ins[d[4:0]] = 0;
        end
    endfunction

    function automatic logic [31:0] model_read(input logic [15:0] a);
        int s = int'(a[6:2]);
        int t = int'(a[6:4]);
        logic [31:0] r = '0;
        if (a[15:7] == 0) return (s >= 1 && s <= N) ? 32'(m_prio[s]) : '0;
        if (a == 16'h080) begin
            for (int k = 1; k <= N; k++) r[k] = pend(k);
            return r;
        end
        if (a == 16'h084) return m_mode;
        if (a[15:7] == 2 && t < T && a[3:2] == 0) return m_en[t];
        if (a[15:7] == 2 && t < T && a[3:2] == 1) return 32'(m_thr[t]);
        return '0;
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] st);
        iob_avalid = 1'b1; iob_addr = a; iob_wdata = d; iob_wstrb = st;
        tick();
        iob_avalid = 1'b0; iob_wstrb = '0;
        model_write(a, d, st);
    endtask

    task automatic bus_rd(input logic [15:0] a, input logic [31:0] e);
        exp_q.push_back(e);
        iob_avalid = 1'b1; iob_addr = a; iob_wstrb = '0;
        tick();
        iob_avalid = 1'b0;
    endtask

    task automatic claim(input int t, input int e);
        int w = winner(t);
        bus_rd(16'(16'h108 + 16 * t), 32'(e));
        if (w != 0) begin
            m_ins[w] = 1;
            if (m_mode[w] && m_cnt[w] > 0) m_cnt[w]--;
        end
    endtask

    task automatic set_src_now(input logic [N-1:0] v);
        for (int s = 1; s <= N; s++) begin
            if (m_mode[s] && v[s-1] && !m_src[s] && m_cnt[s] < MAXC) m_cnt[s]++;
            m_src[s] = v[s-1];
        end
        src = v;
    endtask

    task automatic set_src(input logic [N-1:0] v);
        set_src_now(v);
        tick(3);
    endtask

    initial begin
        int op, t;
        logic [15:0] a;
        model_reset();
        tick(2);
        check("reset_irq", 32'(irq), 0);
        check("reset_rvalid", 32'(iob_rvalid), 0);
        check("reset_rdata", iob_rdata, 0);
        check("ready_const", 32'(iob_ready), 1);
        arst_n_i = 1'b1;
        tick();

        bus_wr(16'h00C, 5, 4'hF);
        bus_wr(16'h100, 32'h1 << 3, 4'hF);
        tick(2);
        check("t1_idle_irq", 32'(irq), 0);
        set_src_now(8'h04);
        tick();
        check("t1_irq_n1", 32'(irq[0]), 0);
        tick();
        check("t1_irq_n2", 32'(irq[0]), 1);
        claim(0, 3);
        tick();
        check("t1_irq_drop", 32'(irq[0]), 0);
        bus_wr(16'h108, 3, 4'hF);
        check("t1_irq_cpl1", 32'(irq[0]), 0);
        tick();
        check("t1_irq_cpl2", 32'(irq[0]), 1);
        set_src(8'h00);
        bus_wr(16'h100, 0, 4'hF);
        tick(3);

        cke_i = 1'b0;
        iob_avalid = 1'b1; iob_addr = 16'h00C; iob_wdata = 7; iob_wstrb = 4'hF;
        tick();
        iob_wstrb = '0;
        tick();
        iob_avalid = 1'b0;
        check("cke_no_rvalid", 32'(iob_rvalid), 0);
        cke_i = 1'b1;
        bus_rd(16'h00C, 5);
        tick(2);

        bus_wr(16'h084, 32'h1 << 1, 4'hF);
        bus_wr(16'h004, 2, 4'hF);
        bus_wr(16'h100, 32'h1 << 1, 4'hF);
        tick(2);
        repeat (10) begin
            set_src_now(8'h01);
            tick();
            set_src_now(8'h00);
            tick();
        end
        tick(2);
        for (int i = 0; i < 9; i++) begin
            claim(0, i < 8 ? 1 : 0);
            tick(3);
            bus_wr(16'h108, 1, 4'hF);
            tick(3);
        end
        bus_wr(16'h084, 0, 4'hF);
        bus_wr(16'h100, 0, 4'hF);
        tick(3);

        bus_wr(16'h008, 3, 4'hF);
        bus_wr(16'h010, 3, 4'hF);
        bus_wr(16'h018, 1, 4'hF);
        bus_wr(16'h110, 32'h54, 4'hF);
        set_src(8'h2A);
        claim(1, 2);
        tick(3);
        claim(1, 4);
        tick(3);
        claim(1, 6);
        tick(3);
        check("t3_all_claimed", 32'(irq), 0);
        bus_wr(16'h118, 2, 4'hF);
        bus_wr(16'h118, 4, 4'hF);
        bus_wr(16'h118, 6, 4'hF);
        set_src(8'h00);
        bus_wr(16'h110, 0, 4'hF);
        tick(3);

        bus_wr(16'h104, 3, 4'hF);
        bus_wr(16'h014, 3, 4'hF);
        bus_wr(16'h100, 32'h1 << 5, 4'hF);
        set_src(8'h10);
        check("t4_at_thr", 32'(irq[0]), 0);
        bus_wr(16'h014, 4, 4'hF);
        check("t4_wr1", 32'(irq[0]), 0);
        tick();
        check("t4_above_thr", 32'(irq[0]), 1);
        set_src(8'h00);
        bus_wr(16'h104, 0, 4'hF);
        bus_wr(16'h100, 0, 4'hF);
        tick(3);

        bus_wr(16'h01C, 2, 4'hF);
        bus_wr(16'h100, 32'h1 << 7, 4'hF);
        bus_wr(16'h110, 32'h1 << 7, 4'hF);
        set_src(8'h40);
        check("t5_both", 32'(irq), 3);
        claim(0, 7);
        tick(2);
        check("t5_blocked", 32'(irq), 0);
        claim(1, 0);
        tick(2);
        bus_wr(16'h118, 7, 4'hF);
        tick(2);
        check("t5_reassert", 32'(irq), 3);

        iob_avalid = 1'b1; iob_addr = 16'h01C; iob_wstrb = '0;
        arst_n_i = 1'b0;
        src = '0;
        #1;
        check("rst_async_irq", 32'(irq), 0);
        @(posedge clk_i); #1;
        iob_avalid = 1'b0;
        check("rst_no_rvalid", 32'(iob_rvalid), 0);
        tick();
        arst_n_i = 1'b1;
        model_reset();
        tick();
        check("rst_irq_after", 32'(irq), 0);
        bus_rd(16'h01C, 0);
        bus_rd(16'h100, 0);
        bus_rd(16'h110, 0);
        bus_rd(16'h104, 0);
        bus_rd(16'h084, 0);
        bus_rd(16'h080, 0);
        bus_rd(16'h108, 0);
        tick(2);

        for (int i = 0; i < 400; i++) begin
            op = $urandom_range(0, 8);
            t = $urandom_range(0, T - 1);
            case (op)
                0: set_src_now(N'($urandom));
                1: bus_wr(16'(4 * $urandom_range(0, 9)), $urandom, 4'($urandom_range(1, 15)));
                2: bus_wr(16'(16'h100 + 16 * $urandom_range(0, 2)), $urandom, 4'($urandom_range(1, 15)));
                3: bus_wr(16'(16'h104 + 16 * t), $urandom_range(0, 4), 4'hF);
                4: bus_wr(16'h084, $urandom, 4'($urandom_range(1, 15)));
                5: claim(t, winner(t));
                6, 7: bus_wr(16'(16'h108 + 16 * t), $urandom_range(0, 9), 4'hF);
                default: begin
                    a = rd_addrs[$urandom_range(0, 14)];
                    bus_rd(a, model_read(a));
                end
            endcase
            tick(3);
            check("rand_irq", 32'(irq), exp_irq());
        end

        tick(3);
        check("sb_drain", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
